// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the front-end redirect sequencer.
// Imported by the interface, the load-use detector and the top.
package pc_redirect_ctrl_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } fe_state_t;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Pipeline-side bundle for the redirect sequencer.
// The master modport is the sequencer; the slave modport is the pipeline/imem side.
interface pc_redirect_ctrl_if
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             ex_valid;
  logic             ex_pc_src;
  logic [XLEN-1:0]  ex_target;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             imem_ready;

  logic             imem_req;
  logic             pc_we;
  logic             pc_sel;
  logic [XLEN-1:0]  redirect_pc;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    input  ex_valid, ex_pc_src, ex_target, ex_mem_read, ex_rd, id_rs1, id_rs2, imem_ready,
    output imem_req, pc_we, pc_sel, redirect_pc, if_id_we, if_id_flush, id_ex_flush,
           redirect_cnt
  );

  modport slave (
    output ex_valid, ex_pc_src, ex_target, ex_mem_read, ex_rd, id_rs1, id_rs2, imem_ready,
    input  imem_req, pc_we, pc_sel, redirect_pc, if_id_we, if_id_flush, id_ex_flush,
           redirect_cnt
  );

endinterface

// File: rtl/pc_redirect_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds an ID source.
// x0 is never a hazard since it is hardwired to zero.
module load_use_detect
  import pc_redirect_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       lu_o
);

  assign lu_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Front-end sequencer: PC write/select, IF/ID and ID/EX control, redirect hold
// while a fetch is outstanding, and a wrapping redirect counter.
//
// state      | meaning
// RUN        | normal fetch; redirect, load-use and fetch-stall handling
// REDIR_WAIT | redirect accepted during a stalled fetch; target held in tgt_q
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_redirect_ctrl_if.master   bus
);

  fe_state_t        state_q, state_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic redir;
  logic lu;

  assign redir = bus.ex_valid && bus.ex_pc_src;

  load_use_detect u_lu (
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rd_i       (bus.ex_rd),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .lu_o          (lu)
  );

  // Redirects are counted when accepted, even if the PC write waits for imem.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (redir) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!bus.imem_ready) begin
            state_d = REDIR_WAIT;
            tgt_d   = bus.ex_target;
          end
        end
      end
      REDIR_WAIT: begin
        if (bus.imem_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.imem_req     = 1'b1;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.redirect_pc  = (state_q == REDIR_WAIT) ? tgt_q : bus.ex_target;
    bus.if_id_we     = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.redirect_cnt = rst ? '0 : cnt_q;

    if (rst) begin
      bus.imem_req    = 1'b0;
      bus.if_id_we    = 1'b0;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (state_q == REDIR_WAIT) begin
      // The word returning now was fetched from the stale path.
      bus.pc_we       = bus.imem_ready;
      bus.pc_sel      = 1'b1;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (redir) begin
      bus.pc_we       = bus.imem_ready;
      bus.pc_sel      = 1'b1;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (lu) begin
      // ID holds; a fetch completing now is simply refetched from the same PC.
      bus.if_id_we    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end else if (!bus.imem_ready) begin
      bus.if_id_flush = 1'b1;
    end else begin
      bus.pc_we       = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level reference model. A second instance with CNT_W=2 covers wrap.
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  pc_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();
  pc_redirect_ctrl_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  assign bus2.ex_valid    = bus.ex_valid;
  assign bus2.ex_pc_src   = bus.ex_pc_src;
  assign bus2.ex_target   = bus.ex_target;
  assign bus2.ex_mem_read = bus.ex_mem_read;
  assign bus2.ex_rd       = bus.ex_rd;
  assign bus2.id_rs1      = bus.id_rs1;
  assign bus2.id_rs2      = bus.id_rs2;
  assign bus2.imem_ready  = bus.imem_ready;

  pc_redirect_ctrl #(.XLEN(32), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pc_redirect_ctrl #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // reference model: "a redirect is pending" flag, held target, total redirects taken
  bit          m_pending = 1'b0;
  logic [31:0] m_tgt     = '0;
  int unsigned m_redirs  = 0;

  logic        e_req, e_we, e_sel, e_sel_care, e_ifwe, e_iff, e_idf;
  logic [31:0] e_rpc;
  logic [15:0] e_cnt16;
  logic [1:0]  e_cnt2;

  task automatic model_expect();
    bit is_redir, is_lu;
    is_redir = bus.ex_valid && bus.ex_pc_src;
    is_lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
            (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
    e_cnt16 = rst ? 16'd0 : 16'(m_redirs % 65536);
    e_cnt2  = rst ? 2'd0  : 2'(m_redirs % 4);
    e_rpc   = m_pending ? m_tgt : bus.ex_target;
    e_sel_care = 1'b0;
    e_sel = 1'b0;
    if (rst) begin
      e_req = 0; e_we = 0; e_sel = 0; e_sel_care = 1; e_ifwe = 0; e_iff = 1; e_idf = 1;
    end else if (m_pending) begin
      e_req = 1; e_we = bus.imem_ready; e_sel = 1; e_sel_care = 1;
      e_ifwe = 1; e_iff = 1; e_idf = 1;
    end else if (is_redir) begin
      e_req = 1; e_we = bus.imem_ready; e_sel = 1; e_sel_care = bus.imem_ready;
      e_ifwe = 1; e_iff = 1; e_idf = 1;
    end else if (is_lu) begin
      e_req = 1; e_we = 0; e_ifwe = 0; e_iff = 0; e_idf = 1;
    end else if (!bus.imem_ready) begin
      e_req = 1; e_we = 0; e_ifwe = 1; e_iff = 1; e_idf = 0;
    end else begin
      e_req = 1; e_we = 1; e_sel = 0; e_sel_care = 1; e_ifwe = 1; e_iff = 0; e_idf = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pending = 0; m_tgt = '0; m_redirs = 0;
    end else if (m_pending) begin
      if (bus.imem_ready) m_pending = 0;
    end else if (bus.ex_valid && bus.ex_pc_src) begin
      m_redirs++;
      if (!bus.imem_ready) begin
        m_pending = 1;
        m_tgt = bus.ex_target;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic src, input logic [31:0] tgt,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic rdy);
    bus.ex_valid = v; bus.ex_pc_src = src; bus.ex_target = tgt;
    bus.ex_mem_read = mr; bus.ex_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.imem_ready = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({bus.imem_req, bus.pc_we, bus.if_id_flush, bus.id_ex_flush} !== 4'b0011)
        $display("FAIL reset_ctl[%0d]: got req/we/iff/idf=%b want 0011", i,
                 {bus.imem_req, bus.pc_we, bus.if_id_flush, bus.id_ex_flush});
      else passed++;
      checks++;
      if (bus.redirect_cnt !== 16'd0)
        $display("FAIL reset_cnt[%0d]: got %0d want 0", i, bus.redirect_cnt);
      else passed++;
      advance();
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.pc_we, bus.pc_sel} !== 3'b110)
      $display("FAIL reset_release: got req/we/sel=%b want 110",
               {bus.imem_req, bus.pc_we, bus.pc_sel});
    else passed++;
    advance();
  endtask

  task automatic test_branch_ready();
    drive(1, 1, 32'h100, 0, 5'd0, 5'd0, 5'd0, 1);
    #1;
    checks++;
    if ({bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush} !== 4'b1111 ||
        bus.redirect_pc !== 32'h100)
      $display("FAIL branch_ready: got we/sel/iff/idf=%b pc=%h want 1111 pc=00000100",
               {bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush}, bus.redirect_pc);
    else passed++;
    advance();
    drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1);
    #1;
    checks++;
    if (bus.redirect_cnt !== 16'd1)
      $display("FAIL branch_cnt: got %0d want 1", bus.redirect_cnt);
    else passed++;
    advance();
  endtask

  task automatic test_redirect_stall();
    int unsigned base;
    base = m_redirs;
    drive(1, 1, 32'h200, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.pc_we, bus.if_id_flush, bus.id_ex_flush} !== 3'b011 ||
          bus.redirect_pc !== 32'h200)
        $display("FAIL stall_wait[%0d]: got we/iff/idf=%b pc=%h want 011 pc=00000200", i,
                 {bus.pc_we, bus.if_id_flush, bus.id_ex_flush}, bus.redirect_pc);
      else passed++;
      advance();
      drive(1, 1, 32'h300, 0, 5'd0, 5'd0, 5'd0, 0);
    end
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush} !== 4'b1111 ||
        bus.redirect_pc !== 32'h200)
      $display("FAIL stall_release: got we/sel/iff/idf=%b pc=%h want 1111 pc=00000200",
               {bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush}, bus.redirect_pc);
    else passed++;
    advance();
    drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1);
    #1;
    checks++;
    if ({bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush} !== 4'b1000 ||
        bus.redirect_cnt !== 16'(base + 1))
      $display("FAIL stall_back_to_run: got we/sel/iff/idf=%b cnt=%0d want 1000 cnt=%0d",
               {bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush},
               bus.redirect_cnt, base + 1);
    else passed++;
    advance();
  endtask

  task automatic test_load_use();
    drive(0, 0, 32'h0, 1, 5'd5, 5'd1, 5'd5, 1);
    #1;
    checks++;
    if ({bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush} !== 4'b0001)
      $display("FAIL load_use: got we/ifwe/iff/idf=%b want 0001",
               {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush});
    else passed++;
    advance();
    drive(0, 0, 32'h0, 0, 5'd5, 5'd1, 5'd5, 1);
    #1;
    checks++;
    if ({bus.pc_we, bus.if_id_we, bus.id_ex_flush} !== 3'b110)
      $display("FAIL load_use_release: got we/ifwe/idf=%b want 110",
               {bus.pc_we, bus.if_id_we, bus.id_ex_flush});
    else passed++;
    advance();
    drive(0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1);
    #1;
    checks++;
    if ({bus.pc_we, bus.if_id_we, bus.id_ex_flush} !== 3'b110)
      $display("FAIL load_use_x0: got we/ifwe/idf=%b want 110",
               {bus.pc_we, bus.if_id_we, bus.id_ex_flush});
    else passed++;
    advance();
  endtask

  task automatic test_priority();
    drive(1, 1, 32'h400, 1, 5'd7, 5'd7, 5'd2, 1);
    #1;
    checks++;
    if ({bus.pc_we, bus.pc_sel, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush} !== 5'b11111 ||
        bus.redirect_pc !== 32'h400)
      $display("FAIL priority: got we/sel/ifwe/iff/idf=%b pc=%h want 11111 pc=00000400",
               {bus.pc_we, bus.pc_sel, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush},
               bus.redirect_pc);
    else passed++;
    advance();
  endtask

  task automatic test_cnt_wrap();
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1);
    advance();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h1000 + 32'(i * 4), 0, 5'd0, 5'd0, 5'd0, 1);
      advance();
    end
    drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1);
    #1;
    checks++;
    if (bus2.redirect_cnt !== 2'd1 || bus.redirect_cnt !== 16'd5)
      $display("FAIL cnt_wrap: got cnt2=%0d cnt16=%0d want cnt2=1 cnt16=5",
               bus2.redirect_cnt, bus.redirect_cnt);
    else passed++;
    drive(1, 1, 32'h5000, 0, 5'd0, 5'd0, 5'd0, 0);
    advance();
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0);
    #1;
    checks++;
    if ({bus.imem_req, bus.pc_we} !== 2'b00 || bus.redirect_cnt !== 16'd0)
      $display("FAIL rst_in_wait: got req/we=%b cnt=%0d want 00 cnt=0",
               {bus.imem_req, bus.pc_we}, bus.redirect_cnt);
    else passed++;
    advance();
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush} !== 4'b1000 ||
        bus.redirect_cnt !== 16'd0 || bus2.redirect_cnt !== 2'd0)
      $display("FAIL rst_wait_to_run: got we/sel/iff/idf=%b cnt=%0d want 1000 cnt=0",
               {bus.pc_we, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush}, bus.redirect_cnt);
    else passed++;
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 7);
      #1;
      model_expect();
      checks++;
      if (bus.imem_req !== e_req || bus.pc_we !== e_we ||
          (e_sel_care && bus.pc_sel !== e_sel) ||
          (!rst && bus.redirect_pc !== e_rpc) ||
          bus.if_id_we !== e_ifwe || bus.if_id_flush !== e_iff ||
          bus.id_ex_flush !== e_idf || bus.redirect_cnt !== e_cnt16 ||
          bus2.redirect_cnt !== e_cnt2)
        $display("FAIL random[%0d]: got req/we/sel/ifwe/iff/idf=%b pc=%h cnt=%0d/%0d want %b pc=%h cnt=%0d/%0d",
                 i, {bus.imem_req, bus.pc_we, bus.pc_sel, bus.if_id_we, bus.if_id_flush,
                 bus.id_ex_flush}, bus.redirect_pc, bus.redirect_cnt, bus2.redirect_cnt,
                 {e_req, e_we, e_sel, e_ifwe, e_iff, e_idf}, e_rpc, e_cnt16, e_cnt2);
      else passed++;
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1);
    @(negedge clk);
    test_reset();
    test_branch_ready();
    test_redirect_stall();
    test_load_use();
    test_priority();
    test_cnt_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
